// File: rtl/bmu_pkg.sv
// Shared definitions for the BMU writeback path: default sizes and the
// layout of one queued writeback entry.
package bmu_pkg;

    localparam int BMU_WBQ_DEPTH = 4;
    localparam int BMU_TAG_W     = 4;

    // One completed BMU result as held in the writeback queue.
    typedef struct packed {
        logic [31:0]          data;
        logic                 err;
        logic [BMU_TAG_W-1:0] tag;
    } bmu_wb_entry_t;

endpackage

// File: rtl/bmu_wbq_fifo.sv
// Storage for the BMU writeback queue: DEPTH entries with wrapping
// read/write pointers and an occupancy count. Flush empties the queue and
// overrides any push or pop in the same cycle. The head is read
// combinationally, so an entry written to an empty queue reaches the head
// on the following cycle.
module bmu_wbq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    // Next pointers and count; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    // Pointer/count registers and entry writes; entries are zeroed on reset so the head reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/bmu_wb_queue.sv
// Writeback queue behind the BMU. Delays the issue valid/tag by one cycle to
// line up with the BMU's registered result, queues completed results and
// drains them over wb_valid/wb_ready. Also raises stall_out so issue never
// launches an op that could not be stored, and records a sticky overflow.
//
// Handshake: an entry leaves the queue in any cycle where wb_valid and
// wb_ready are both high; while wb_valid is high and wb_ready low the head
// fields hold stable.
//
// Optional: define BMU_WBQ_ERRCNT_EN to add the saturating err_count output
// that counts popped entries carrying the error flag.
module bmu_wb_queue
    import bmu_pkg::*;
#(
    parameter int DEPTH = BMU_WBQ_DEPTH,
    parameter int TAG_W = BMU_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [TAG_W-1:0] tag_in,
    input  logic [31:0]      result_in,
    input  logic             error_in,
    input  logic             flush,
    output logic             stall_out,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_data,
    output logic             wb_error,
    output logic [TAG_W-1:0] wb_tag,
`ifdef BMU_WBQ_ERRCNT_EN
    output logic [15:0]      err_count,
`endif
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;
    localparam int EW = 33 + TAG_W;

    logic             align_v_q, align_v_d;
    logic [TAG_W-1:0] align_tag_q, align_tag_d;
    logic             overflow_q, overflow_d;
    logic             push, pop, full, empty;
    logic [AW:0]      count;
    logic [EW-1:0]    head;

    // Align stage inputs; a flush kills the op being issued this cycle.
    always_comb begin
        align_v_d   = valid_in & ~flush;
        align_tag_d = tag_in;
    end

    // A capture is lost only when the queue is full with no pop to make room.
    always_comb begin
        pop        = wb_valid & wb_ready & ~flush;
        push       = align_v_q & (~full | pop) & ~flush;
        overflow_d = overflow_q | (align_v_q & full & ~pop & ~flush);
    end

    // Align stage and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            align_v_q   <= 1'b0;
            align_tag_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            align_v_q   <= align_v_d;
            align_tag_q <= align_tag_d;
            overflow_q  <= overflow_d;
        end
    end

    bmu_wbq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({result_in, error_in, align_tag_q}),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // Conservative stall: counts the in-flight op but ignores any concurrent pop.
    assign stall_out = ({1'b0, count} + CW'(align_v_q)) >= CW'(DEPTH);
    assign wb_valid  = ~empty;
    assign wb_data   = head[EW-1 -: 32];
    assign wb_error  = head[TAG_W];
    assign wb_tag    = head[TAG_W-1:0];
    assign overflow  = overflow_q;

`ifdef BMU_WBQ_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Count errored pops, saturating at all ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (pop && wb_error && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end

    // Error counter register; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`endif

endmodule
